// File: rtl/cms_trace_axis_writer_pkg.sv
// cms_trace_axis_writer_pkg: shared widths, trace item layout and flush FSM states for the CMS trace writer
package cms_trace_axis_writer_pkg;
  localparam int XLEN = 64;
  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int CLK_COUNTER_WIDTH = 64;
  localparam int AXI_DATA_WIDTH = 1024;
  localparam int CTRL_DATA_WIDTH = 64;
  localparam int CMS_FIFO_DEPTH = 16;
  localparam int CMS_HALT_MARGIN = 4;
  localparam int CMS_OVF_COUNT_WIDTH = 32;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    logic [CLK_COUNTER_WIDTH-1:0] clk;
  } trace_item_t;
  localparam int ITEM_WIDTH = $bits(trace_item_t);
  typedef enum logic [1:0] {FLUSH_IDLE, FLUSH_PENDING, FLUSH_PAD} flush_state_t;
endpackage

// File: rtl/cms_trace_axis_writer_fifo.sv
// cms_sync_fifo: width/depth parameterised synchronous FIFO with show-ahead read and occupancy count
module cms_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign rdata = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/cms_trace_axis_writer.sv
// cms_trace_axis_writer: buffers filtered trace items and streams them as AXI4-Stream beats with tlast, flush and CPU halt.
// Occupancy counts the FIFO plus the registered output slot, so FIFO_DEPTH is the total item capacity.
module cms_trace_axis_writer #(
  parameter int ITEM_WIDTH = cms_trace_axis_writer_pkg::ITEM_WIDTH,
  parameter int AXI_DATA_WIDTH = cms_trace_axis_writer_pkg::AXI_DATA_WIDTH,
  parameter int FIFO_DEPTH = cms_trace_axis_writer_pkg::CMS_FIFO_DEPTH,
  parameter int HALT_MARGIN = cms_trace_axis_writer_pkg::CMS_HALT_MARGIN,
  parameter int CTRL_DATA_WIDTH = cms_trace_axis_writer_pkg::CTRL_DATA_WIDTH,
  parameter int OVF_COUNT_WIDTH = cms_trace_axis_writer_pkg::CMS_OVF_COUNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          item_valid,
  input  logic [ITEM_WIDTH-1:0]         item_data,
  input  logic [63:0]                   clk_counter,
  input  logic                          halting_on_full_fifo_enabled,
  input  logic [CTRL_DATA_WIDTH-1:0]    tlast_interval,
  input  logic                          flush_req,
  output logic [AXI_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          halt_cpu,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [OVF_COUNT_WIDTH-1:0]    overflow_count,
  output logic [63:0]                   last_write_timestamp
);
  import cms_trace_axis_writer_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [ITEM_WIDTH-1:0] head, src;
  logic [CW-1:0] fcnt, total;
  logic fempty, ffull, xfer, slot_free, load_item, load_pad, bypass, accept, push, pop, drop;
  logic is_last, hit, tlast_new, drained, flush_pending;
  logic [CTRL_DATA_WIDTH-1:0] beats, beats_eff;
  logic [CTRL_DATA_WIDTH:0] beats_next;
  flush_state_t state, state_nxt;
  cms_sync_fifo #(.WIDTH(ITEM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata(item_data), .pop(pop),
    .rdata(head), .count(fcnt), .full(ffull), .empty(fempty)
  );
  // An empty FIFO lets a fresh item go straight into the output slot for one-cycle latency
  always_comb begin
    total = fcnt + CW'(m_axis_tvalid);
    xfer = m_axis_tvalid & m_axis_tready;
    slot_free = ~m_axis_tvalid | m_axis_tready;
    load_item = slot_free & (~fempty | item_valid);
    bypass = load_item & fempty;
    accept = item_valid & ((total < CW'(FIFO_DEPTH)) | xfer);
    push = accept & ~bypass & ~ffull;
    pop = load_item & ~fempty;
    drop = item_valid & ~accept;
    src = fempty ? item_data : head;
    is_last = fempty | ((fcnt == CW'(1)) & ~item_valid);
    beats_eff = xfer ? (m_axis_tlast ? '0 : beats + CTRL_DATA_WIDTH'(1)) : beats;
    beats_next = {1'b0, beats_eff} + (CTRL_DATA_WIDTH+1)'(1);
    hit = (tlast_interval == '0) | (beats_next >= {1'b0, tlast_interval});
    tlast_new = hit | (flush_pending & is_last);
    drained = ~m_axis_tvalid & fempty & ~item_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FLUSH_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH_IDLE:    state_nxt = flush_req ? FLUSH_PENDING : FLUSH_IDLE;
      FLUSH_PENDING: state_nxt = ((xfer & m_axis_tlast) | (drained & beats == '0)) ? FLUSH_IDLE :
                                 drained ? FLUSH_PAD : FLUSH_PENDING;
      FLUSH_PAD:     state_nxt = xfer ? FLUSH_IDLE : FLUSH_PAD;
      default:       state_nxt = FLUSH_IDLE;
    endcase
  end
  always_comb begin
    flush_pending = state == FLUSH_PENDING;
    load_pad = flush_pending & drained & (beats != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      beats <= '0;
      last_write_timestamp <= '0;
      overflow_count <= '0;
      halt_cpu <= 1'b0;
    end else begin
      if (load_item) begin
        m_axis_tdata <= AXI_DATA_WIDTH'(src);
        m_axis_tlast <= tlast_new;
        m_axis_tvalid <= 1'b1;
      end else if (load_pad) begin
        m_axis_tdata <= '0;
        m_axis_tlast <= 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (xfer) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast <= 1'b0;
      end
      if (xfer) begin
        beats <= m_axis_tlast ? '0 : beats + CTRL_DATA_WIDTH'(1);
        last_write_timestamp <= clk_counter;
      end
      if (drop && !(&overflow_count)) overflow_count <= overflow_count + OVF_COUNT_WIDTH'(1);
      halt_cpu <= halting_on_full_fifo_enabled & (total >= CW'(FIFO_DEPTH - HALT_MARGIN));
    end
  end
  assign m_axis_tkeep = '1;
  assign fifo_count = total;
endmodule

// File: tb/tb_cms_trace_axis_writer.sv
// tb_cms_trace_axis_writer: scoreboard bench for the CMS trace AXIS writer
module tb_cms_trace_axis_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic item_valid = 1'b0;
  logic [159:0] item_data = '0;
  logic [63:0] clk_counter = '0;
  logic halt_en = 1'b0;
  logic [63:0] tlast_interval = 64'd4;
  logic flush_req = 1'b0;
  logic tready = 1'b0;
  logic [1023:0] tdata;
  logic [127:0] tkeep;
  logic tvalid, tlast, halt;
  logic [4:0] fifo_count;
  logic [31:0] overflow_count;
  logic [63:0] last_write_timestamp;
  typedef struct packed {logic [159:0] d; logic l;} beat_t;
  beat_t sb[$];
  beat_t mb;
  int n_chk = 0;
  int n_fail = 0;
  int n_beats = 0;
  int nb;
  logic [63:0] exp_ts = '0;
  logic stalled = 1'b0;
  logic [159:0] held_d = '0;
  logic held_l = 1'b0;

  cms_trace_axis_writer dut (
    .clk(clk), .rst_n(rst_n), .item_valid(item_valid), .item_data(item_data),
    .clk_counter(clk_counter), .halting_on_full_fifo_enabled(halt_en),
    .tlast_interval(tlast_interval), .flush_req(flush_req),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .halt_cpu(halt),
    .fifo_count(fifo_count), .overflow_count(overflow_count),
    .last_write_timestamp(last_write_timestamp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_counter <= clk_counter + 64'd1;

  task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled) begin
        check("hold_valid", 160'(tvalid), 160'(1));
        check("hold_data", tdata[159:0], held_d);
        check("hold_last", 160'(tlast), 160'(held_l));
      end
      if (tvalid && tready) begin
        n_beats++;
        exp_ts = clk_counter;
        check("beat_expected", 160'(sb.size() != 0), 160'(1));
        if (sb.size() != 0) begin
          mb = sb.pop_front();
          check("tdata", tdata[159:0], mb.d);
          check("tlast", 160'(tlast), 160'(mb.l));
          check("tdata_msb", 160'(|tdata[1023:160]), 160'(0));
        end
      end
      stalled = tvalid && !tready;
      held_d = tdata[159:0];
      held_l = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || tvalid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 160'(sb.size()), 160'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    item_valid = 1'b0;
    flush_req = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 160'(tvalid), 160'(0));
    check("rst_tlast", 160'(tlast), 160'(0));
    check("rst_tdata", tdata[159:0], 160'(0));
    check("rst_tkeep", 160'(&tkeep), 160'(1));
    check("rst_halt", 160'(halt), 160'(0));
    check("rst_count", 160'(fifo_count), 160'(0));
    check("rst_ovf", 160'(overflow_count), 160'(0));
    check("rst_ts", 160'(last_write_timestamp), 160'(0));
    rst_n = 1'b1;
    tready = 1'b1;
    tlast_interval = 64'd4;
    // back-to-back items, interval 4
    for (int i = 1; i <= 8; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(i);
      sb.push_back('{d: 160'(i), l: (i % 4 == 0)});
      @(negedge clk);
      if (i == 1) check("lat_n", 160'(tvalid), 160'(0));
      if (i == 2) check("lat_n1", 160'(tvalid), 160'(1));
    end
    tick();
    item_valid = 1'b0;
    wait_drain("t1_drain");
    // fill with halting enabled, one drop, then push while popping at full
    tready = 1'b0;
    halt_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h200 + i);
      if (i <= 16) sb.push_back('{d: 160'(32'h200 + i), l: (i % 4 == 0)});
      @(negedge clk);
      if (i == 13) begin
        check("cnt12", 160'(fifo_count), 160'(12));
        check("halt_pre", 160'(halt), 160'(0));
      end
      if (i == 14) check("halt_set", 160'(halt), 160'(1));
    end
    tick();
    item_valid = 1'b0;
    @(negedge clk);
    check("t2_ovf", 160'(overflow_count), 160'(1));
    check("t2_count", 160'(fifo_count), 160'(16));
    check("t2_halt", 160'(halt), 160'(1));
    for (int k = 1; k <= 4; k++) begin
      tick();
      tready = 1'b1;
      item_valid = 1'b1;
      item_data = 160'(32'h210 + k);
      sb.push_back('{d: 160'(32'h210 + k), l: (k == 4)});
    end
    tick();
    item_valid = 1'b0;
    wait_drain("t2_drain");
    check("t2_ovf_nodrop", 160'(overflow_count), 160'(1));
    tick();
    @(negedge clk);
    check("t2_halt_clr", 160'(halt), 160'(0));
    // halting disabled overflow
    halt_en = 1'b0;
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h300 + i);
      if (i <= 16) sb.push_back('{d: 160'(32'h300 + i), l: (i % 4 == 0)});
    end
    tick();
    item_valid = 1'b0;
    @(negedge clk);
    check("t3_ovf", 160'(overflow_count), 160'(4));
    check("t3_count", 160'(fifo_count), 160'(16));
    check("t3_halt", 160'(halt), 160'(0));
    tready = 1'b1;
    wait_drain("t3_drain");
    // flush closes queued packet, pads an open one, ignored when idle
    tlast_interval = 64'd10;
    tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h400 + i);
      sb.push_back('{d: 160'(32'h400 + i), l: (i == 3)});
    end
    tick();
    item_valid = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tready = 1'b1;
    wait_drain("t4_flush_drain");
    for (int i = 1; i <= 2; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h500 + i);
      sb.push_back('{d: 160'(32'h500 + i), l: 1'b0});
    end
    tick();
    item_valid = 1'b0;
    wait_drain("t4_open_drain");
    tick();
    flush_req = 1'b1;
    sb.push_back('{d: 160'(0), l: 1'b1});
    tick();
    flush_req = 1'b0;
    wait_drain("t4_pad_drain");
    nb = n_beats;
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_flush_beats", 160'(n_beats - nb), 160'(0));
    // random backpressure
    tlast_interval = 64'd3;
    for (int i = 1; i <= 12; i++) begin
      tick();
      tready = 1'($urandom_range(0, 1));
      item_valid = 1'b1;
      item_data = 160'(32'h600 + i);
      sb.push_back('{d: 160'(32'h600 + i), l: (i % 3 == 0)});
    end
    tick();
    item_valid = 1'b0;
    repeat (30) begin
      tick();
      tready = 1'($urandom_range(0, 1));
    end
    tready = 1'b1;
    wait_drain("t5_drain");
    check("t5_timestamp", 160'(last_write_timestamp), 160'(exp_ts));
    // reset mid-packet
    tlast_interval = 64'd5;
    tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h700 + i);
    end
    tick();
    item_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", 160'(tvalid), 160'(1));
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_tvalid", 160'(tvalid), 160'(0));
    check("t6_tlast", 160'(tlast), 160'(0));
    check("t6_count", 160'(fifo_count), 160'(0));
    check("t6_ts", 160'(last_write_timestamp), 160'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      item_valid = 1'b1;
      item_data = 160'(32'h800 + i);
      sb.push_back('{d: 160'(32'h800 + i), l: (i == 5)});
    end
    tick();
    item_valid = 1'b0;
    wait_drain("t6_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
